// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a multi-cycle shift-add multiplier.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   in_valid / in_ready request handshake for a, b, op_code
//   a, b [N-1:0]        operands (shift amount is b[SHW-1:0])
//   op_code [2:0]       0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
//   out_valid/out_ready result handshake
//   result [N-1:0]      operation result
//   zero_f, neg_f, c_out_f, overflow_f  status flags for result
//   busy                high while a multiply is iterating
//
// Every request passes through BUSY: one cycle for the single-cycle ops,
// N shift-add iterations plus one finishing cycle for MUL. DONE holds the
// result until it is taken; a new request may be accepted in that same cycle.
module alu_pipe #(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero_f,
  output logic         neg_f,
  output logic         c_out_f,
  output logic         overflow_f,
  output logic         busy
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  localparam int         CW     = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic [N-1:0]   opa_p0;
  logic [N-1:0]   opb_p0;
  logic [2:0]     op_p0;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic [N+1:0]   alu_p1;   // {carry, overflow, result}

  // Single-cycle operations. Shifts use an N+1-bit window so the bit that
  // falls off the end lands in the extra position and becomes the carry;
  // a zero shift leaves that position at 0.
  function automatic logic [N+1:0] alu_eval(input logic [N-1:0] x,
                                            input logic [N-1:0] y,
                                            input logic [2:0]   op);
    logic [N:0]     wide;
    logic [N-1:0]   r;
    logic [SHW-1:0] sh;
    logic           c;
    logic           v;
    wide = '0;
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    sh   = y[SHW-1:0];
    case (op)
      OP_ADD: begin
        wide = {1'b0, x} + {1'b0, y};
        r    = wide[N-1:0];
        c    = wide[N];
        v    = (x[N-1] == y[N-1]) && (r[N-1] != x[N-1]);
      end
      OP_SUB: begin
        wide = {1'b0, x} - {1'b0, y};
        r    = wide[N-1:0];
        c    = wide[N];
        v    = (x[N-1] != y[N-1]) && (r[N-1] != x[N-1]);
      end
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_SHL: begin
        wide = {1'b0, x} << sh;
        r    = wide[N-1:0];
        c    = wide[N];
      end
      OP_SHR: begin
        wide = {x, 1'b0} >> sh;
        r    = wide[N:1];
        c    = wide[0];
      end
      default: ;
    endcase
    return {c, v, r};
  endfunction

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    alu_p1 = alu_eval(opa_p0, opb_p0, op_p0);
  end

  // p0: capture on handshake; p1: compute / iterate, register result in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      result     <= '0;
      zero_f     <= 1'b0;
      neg_f      <= 1'b0;
      c_out_f    <= 1'b0;
      overflow_f <= 1'b0;
      opa_p0     <= '0;
      opb_p0     <= '0;
      op_p0      <= OP_ADD;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: ;
        BUSY: begin
          if (op_p0 == OP_MUL) begin
            if (cnt == CW'(N)) begin
              result     <= acc[N-1:0];
              zero_f     <= (acc[N-1:0] == '0);
              neg_f      <= acc[N-1];
              c_out_f    <= |acc[2*N-1:N];
              overflow_f <= 1'b0;
              busy       <= 1'b0;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              if (mplier[0]) acc <= acc + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
              cnt    <= cnt + 1'b1;
            end
          end else begin
            result     <= alu_p1[N-1:0];
            zero_f     <= (alu_p1[N-1:0] == '0);
            neg_f      <= alu_p1[N-1];
            overflow_f <= alu_p1[N];
            c_out_f    <= alu_p1[N+1];
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A handshake overrides the DONE->IDLE move, giving back-to-back issue.
      if (accept) begin
        opa_p0 <= a;
        opb_p0 <= b;
        op_p0  <= op_code;
        acc    <= '0;
        mcand  <= {{N{1'b0}}, a};
        mplier <= b;
        cnt    <= '0;
        busy   <= (op_code == OP_MUL);
        state  <= BUSY;
      end
    end
  end

endmodule
